// File: rtl/lsu_pkg.sv
// Shared constants for the data-memory load/store unit: funct3 codes, FSM states, lane count.
package lsu_pkg;

  localparam int unsigned LSU_XLEN  = 32;
  localparam int unsigned NUM_LANES = LSU_XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  // Stores have no unsigned variants; loads add BU/HU.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads, little-endian.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rd_word,
  output logic [XLEN/8-1:0] wmask,
  output logic [XLEN-1:0]   st_data,
  output logic [XLEN-1:0]   ld_data,
  output logic              misalign
);

  localparam int unsigned LANES = XLEN / 8;

  logic [4:0]  shamt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign shamt = {offset, 3'b000};

  always_comb begin
    wmask    = '0;
    misalign = 1'b0;
    ld_data  = '0;
    st_data  = wdata << shamt;
    ld_byte  = 8'(rd_word >> shamt);
    ld_half  = 16'(rd_word >> shamt);
    case (funct3[1:0])
      F3_B[1:0]: begin
        wmask   = LANES'(1) << offset;
        ld_data = funct3[2] ? {{(XLEN-8){1'b0}}, ld_byte}
                            : {{(XLEN-8){ld_byte[7]}}, ld_byte};
      end
      F3_H[1:0]: begin
        wmask    = LANES'(3) << {offset[1], 1'b0};
        misalign = offset[0];
        ld_data  = funct3[2] ? {{(XLEN-16){1'b0}}, ld_half}
                             : {{(XLEN-16){ld_half[15]}}, ld_half};
      end
      F3_W[1:0]: begin
        wmask    = '1;
        misalign = (offset != 2'b00);
        ld_data  = rd_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory with integrated RV32 load/store unit and sequential clear sweep.
module data_memory_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic              busy
);

  localparam int unsigned LANES  = XLEN / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WIDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [0:0]        state, state_nxt;
  logic [IDX_W-1:0]  clr_idx;
  logic [XLEN-1:0]   mem [DEPTH];

  logic [WIDX_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range, misalign, legal, fault;
  logic              accept, store_en, load_en;
  logic [LANES-1:0]  wmask;
  logic [XLEN-1:0]   st_data, ld_data, rd_word;

  assign word_idx = addr[ADDR_W-1:2];
  assign mem_idx  = IDX_W'(word_idx);
  assign rd_word  = mem[mem_idx];

  // Range check only exists when the address space exceeds the array.
  generate
    if (DEPTH >= (2 ** WIDX_W)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = (word_idx < WIDX_W'(DEPTH));
    end
  endgenerate

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3   (funct3),
    .offset   (addr[1:0]),
    .wdata    (wdata),
    .rd_word  (rd_word),
    .wmask    (wmask),
    .st_data  (st_data),
    .ld_data  (ld_data),
    .misalign (misalign)
  );

  assign legal     = f3_legal(we, funct3);
  assign fault     = !legal || misalign || !in_range;
  assign req_ready = (state == ST_IDLE) && !clr;
  assign busy      = (state == ST_CLEAR);
  assign accept    = req_valid && req_ready;
  assign store_en  = accept && we && !fault;
  assign load_en   = accept && !we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_idx == LAST_IDX) state_nxt = ST_IDLE;
      ST_IDLE:  if (clr) state_nxt = ST_CLEAR;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Sweep index parks at 0 outside CLEAR so every entry into CLEAR starts at word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx <= '0;
    end else if ((state == ST_CLEAR) && (clr_idx != LAST_IDX)) begin
      clr_idx <= clr_idx + IDX_W'(1);
    end else begin
      clr_idx <= '0;
    end
  end

  // Array carries no reset; contents are zeroed only by the sweep.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (store_en) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (wmask[l]) mem[mem_idx][8*l +: 8] <= st_data[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      rdata_valid <= load_en;
      err         <= accept && fault;
      if (load_en) rdata <= fault ? '0 : ld_data;
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench: directed scenarios plus randomized traffic against a byte-array model.
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  logic        rst, clr, req_valid, we;
  logic [2:0]  funct3;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        req_ready, rdata_valid, err, busy;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mbytes [256];
  logic [31:0] last_rd;
  logic [31:0] obs_rd, exp_rd;
  logic        obs_v, exp_v, obs_e, exp_e;

  data_memory_lsu dut (
    .clk(clk), .rst(rst), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .we(we), .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rdata_valid(rdata_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_zero();
    for (int i = 0; i < 256; i++) mbytes[i] = 8'h00;
  endtask

  // Drive one request at a negedge, sample the registered response at the next negedge, update model.
  task automatic op(input logic w, input logic [2:0] f, input logic [7:0] a, input logic [31:0] d);
    int size;
    bit bad;
    logic [31:0] v;
    we = w; funct3 = f; addr = a; wdata = d; req_valid = 1'b1;
    @(negedge clk);
    obs_rd = rdata; obs_v = rdata_valid; obs_e = err;
    size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    bad  = w ? (f > 3'd2) : (f == 3'd3 || f == 3'd6 || f == 3'd7);
    bad  = bad || ((int'(a) % size) != 0) || ((int'(a) / 4) >= 64);
    exp_v = !w;
    exp_e = bad;
    if (w && !bad) begin
      for (int i = 0; i < size; i++) mbytes[int'(a) + i] = d[8*i +: 8];
    end
    if (!w) begin
      if (bad) begin
        last_rd = 32'h0;
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mbytes[int'(a) + i];
        if (!f[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        else if (!f[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        last_rd = v;
      end
    end
    exp_rd = last_rd;
  endtask

  task automatic test_reset();
    int bad_cycles;
    rst = 1'b1; clr = 1'b0; req_valid = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 8'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_status busy=%b ready=%b want busy=1 ready=0", busy, req_ready);
    end
    checks++;
    if (rdata !== 32'h0 || rdata_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs rdata=%h rv=%b err=%b want 0/0/0", rdata, rdata_valid, err);
    end
    rst = 1'b0;
    model_zero();
    last_rd = 32'h0;
    bad_cycles = 0;
    for (int i = 0; i < 64; i++) begin
      if (busy !== 1'b1 || req_ready !== 1'b0) bad_cycles++;
      @(negedge clk);
    end
    checks++;
    if (bad_cycles != 0) begin
      errors++; $display("FAIL reset_sweep_busy bad_cycles=%0d want 0", bad_cycles);
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_sweep_done busy=%b ready=%b want 0/1", busy, req_ready);
    end
    for (int w = 0; w < 64; w++) begin
      op(1'b0, 3'b010, 8'(w * 4), 32'h0);
      checks++;
      if (obs_rd !== 32'h0 || obs_v !== 1'b1 || obs_e !== 1'b0) begin
        errors++; $display("FAIL cleared_word addr=%h rdata=%h rv=%b err=%b want 0/1/0", w * 4, obs_rd, obs_v, obs_e);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_extension();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [7:0]  ads [4] = '{8'h10, 8'h13, 8'h12, 8'h10};
    logic [31:0] kws [4] = '{32'hFFFFFFEF, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    op(1'b1, 3'b010, 8'h10, 32'hDEADBEEF);
    checks++;
    if (obs_v !== 1'b0 || obs_e !== 1'b0) begin
      errors++; $display("FAIL ext_store rv=%b err=%b want 0/0", obs_v, obs_e);
    end
    for (int i = 0; i < 4; i++) begin
      op(1'b0, f3s[i], ads[i], 32'h0);
      checks++;
      if (obs_rd !== kws[i] || obs_rd !== exp_rd || obs_v !== 1'b1 || obs_e !== 1'b0) begin
        errors++; $display("FAIL ext_load f3=%b addr=%h rdata=%h rv=%b err=%b want %h/1/0", f3s[i], ads[i], obs_rd, obs_v, obs_e, kws[i]);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_lanes();
    op(1'b1, 3'b010, 8'h20, 32'h11223344);
    op(1'b1, 3'b000, 8'h21, 32'h000000AA);
    op(1'b1, 3'b001, 8'h22, 32'h00005566);
    op(1'b0, 3'b010, 8'h20, 32'h0);
    checks++;
    if (obs_rd !== 32'h5566AA44 || obs_rd !== exp_rd || obs_v !== 1'b1) begin
      errors++; $display("FAIL lane_merge rdata=%h rv=%b want 5566aa44/1", obs_rd, obs_v);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_faults();
    op(1'b1, 3'b010, 8'h04, 32'hA5A5A5A5);
    op(1'b0, 3'b001, 8'h01, 32'h0);
    checks++;
    if (obs_e !== 1'b1 || obs_v !== 1'b1 || obs_rd !== 32'h0) begin
      errors++; $display("FAIL fault_lh_odd err=%b rv=%b rdata=%h want 1/1/0", obs_e, obs_v, obs_rd);
    end
    op(1'b1, 3'b010, 8'h06, 32'h0BADF00D);
    checks++;
    if (obs_e !== 1'b1 || obs_v !== 1'b0) begin
      errors++; $display("FAIL fault_sw_mis err=%b rv=%b want 1/0", obs_e, obs_v);
    end
    op(1'b0, 3'b010, 8'h04, 32'h0);
    checks++;
    if (obs_rd !== 32'hA5A5A5A5 || obs_e !== 1'b0) begin
      errors++; $display("FAIL fault_no_write rdata=%h err=%b want a5a5a5a5/0", obs_rd, obs_e);
    end
    op(1'b0, 3'b011, 8'h04, 32'h0);
    checks++;
    if (obs_e !== 1'b1 || obs_v !== 1'b1 || obs_rd !== 32'h0) begin
      errors++; $display("FAIL fault_load_f3 err=%b rv=%b rdata=%h want 1/1/0", obs_e, obs_v, obs_rd);
    end
    op(1'b1, 3'b100, 8'h04, 32'hFFFFFFFF);
    checks++;
    if (obs_e !== 1'b1 || obs_v !== 1'b0) begin
      errors++; $display("FAIL fault_store_f3 err=%b rv=%b want 1/0", obs_e, obs_v);
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || rdata_valid !== 1'b0) begin
      errors++; $display("FAIL fault_pulse err=%b rv=%b want 0/0", err, rdata_valid);
    end
    op(1'b0, 3'b010, 8'h04, 32'h0);
    checks++;
    if (obs_rd !== 32'hA5A5A5A5 || obs_rd !== exp_rd) begin
      errors++; $display("FAIL fault_word_intact rdata=%h want a5a5a5a5", obs_rd);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [7:0]  a;
    int          mode;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rdata_valid !== 1'b0 || err !== 1'b0 || rdata !== last_rd) begin
          errors++; $display("FAIL rand_idle rv=%b err=%b rdata=%h want 0/0/%h", rdata_valid, err, rdata, last_rd);
        end
      end
      f    = 3'($urandom_range(0, 7));
      a    = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 3);
      if (mode == 1) a = a & 8'hFC;
      else if (mode == 2) a = a & 8'hFE;
      op(1'($urandom_range(0, 1)), f, a, $urandom);
      checks++;
      if (obs_rd !== exp_rd || obs_v !== exp_v || obs_e !== exp_e) begin
        errors++; $display("FAIL rand_op we=%b f3=%b addr=%h rdata=%h rv=%b err=%b want %h/%b/%b",
                           we, f, a, obs_rd, obs_v, obs_e, exp_rd, exp_v, exp_e);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_soft_clear();
    int bad_cycles;
    op(1'b1, 3'b010, 8'h30, 32'h12345678);
    req_valid = 1'b0;
    clr = 1'b1; req_valid = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 8'h30; wdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL clr_blocks_ready ready=%b want 0", req_ready);
    end
    @(negedge clk);
    clr = 1'b0; req_valid = 1'b0;
    model_zero();
    bad_cycles = 0;
    for (int i = 0; i < 64; i++) begin
      if (busy !== 1'b1 || req_ready !== 1'b0) bad_cycles++;
      @(negedge clk);
    end
    checks++;
    if (bad_cycles != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL clr_busy bad_cycles=%0d busy_after=%b want 0/0", bad_cycles, busy);
    end
    op(1'b0, 3'b010, 8'h30, 32'h0);
    checks++;
    if (obs_rd !== 32'h0 || obs_rd !== exp_rd || obs_v !== 1'b1) begin
      errors++; $display("FAIL clr_word rdata=%h rv=%b want 0/1", obs_rd, obs_v);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int bad_cycles;
    op(1'b1, 3'b010, 8'h08, 32'h77665544);
    req_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_zero();
    last_rd = 32'h0;
    checks++;
    if (rdata !== 32'h0 || rdata_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midclr_reset_out rdata=%h rv=%b err=%b want 0/0/0", rdata, rdata_valid, err);
    end
    bad_cycles = 0;
    for (int i = 0; i < 64; i++) begin
      if (busy !== 1'b1) bad_cycles++;
      @(negedge clk);
    end
    checks++;
    if (bad_cycles != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL midclr_restart bad_cycles=%0d busy_after=%b want 0/0", bad_cycles, busy);
    end
    op(1'b1, 3'b010, 8'h08, 32'hC001D00D);
    checks++;
    if (obs_v !== 1'b0 || obs_e !== 1'b0) begin
      errors++; $display("FAIL b2b_store rv=%b err=%b want 0/0", obs_v, obs_e);
    end
    op(1'b0, 3'b010, 8'h08, 32'h0);
    checks++;
    if (obs_rd !== 32'hC001D00D || obs_rd !== exp_rd || obs_v !== 1'b1) begin
      errors++; $display("FAIL b2b_load rdata=%h rv=%b want c001d00d/1", obs_rd, obs_v);
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rdata_valid !== 1'b0 || rdata !== 32'hC001D00D) begin
      errors++; $display("FAIL b2b_hold rv=%b rdata=%h want 0/c001d00d", rdata_valid, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_extension();
    test_lanes();
    test_faults();
    test_random();
    test_soft_clear();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Parametrised, byte-addressed data memory for the RISC-V datapath, with a built-in load/store unit.
- Supports RV32 byte, half and word loads and stores, with sign or zero extension on loads.
- Detects misaligned, out-of-range and illegal-funct3 accesses.
- Clears the array with a sequential sweep after reset or on request.
- Sits between the ALU result/rs2 path and the writeback mux; the one-cycle registered read feeds writeback.

Parameters:
- XLEN, 32, data word width in bits. Fixed to a multiple of 8; only 32 is verified.
- DEPTH, 64, number of XLEN-bit words in the array.
- ADDR_W, 8, byte-address width. Word index is addr[ADDR_W-1:2].

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  soft-clear request, sampled in IDLE.
- req_valid  input  1  access request.
- req_ready  output  1  high when a request is accepted this cycle; equals (state==IDLE) && !clr.
- we  input  1  1 = store, 0 = load.
- funct3  input  3  RV access size/sign code.
- addr  input  ADDR_W  byte address.
- wdata  input  XLEN  store data; the low bytes are used for SB/SH.
- rdata  output  XLEN  load result, extended.
- rdata_valid  output  1  one-cycle pulse, one cycle after an accepted load.
- err  output  1  one-cycle pulse, one cycle after an accepted faulty access.
- busy  output  1  high while in CLEAR.

Behaviour:
- States:
  - CLEAR: writes 0 to word clr_idx each cycle. Transitions to IDLE after writing word DEPTH-1.
  - IDLE: serves requests.
- Async reset:
  - state=CLEAR, clr_idx=0, rdata=0, rdata_valid=0, err=0, busy=1.
  - A reset mid-CLEAR or mid-access restarts the sweep at index 0.
  - A full clear takes DEPTH cycles after rst deasserts.
- Soft clear: clr=1 in IDLE enters CLEAR next edge with clr_idx=0. It wins over a simultaneous req_valid, which is not accepted. clr is ignored while in CLEAR.
- Accept: req_valid && req_ready at posedge.
- funct3 decoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Fault conditions (err=1 next cycle):
  - Load funct3 011/110/111, or store funct3 with bit2=1 or funct3=011.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index >= DEPTH.
- On a fault: no array write; for a load, rdata_valid=1 and rdata=0.
- Stores: byte-lane write on the accept edge.
  - SB writes lane addr[1:0].
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all lanes.
  - Other lanes are unchanged; little-endian.
- Loads: the array is read on the accept edge; rdata and rdata_valid update on that edge, so the result is visible the cycle after acceptance (latency 1).
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - rdata holds its value until the next accepted load or reset. rdata_valid is low otherwise.
- Store then load to the same word on the next cycle returns the newly written bytes; there is no bypass hazard.
- Stores never assert rdata_valid.
- The array has no reset of its own; clearing happens only via the CLEAR sweep.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum {CLEAR, IDLE};
  - the lane-count constant XLEN/8.
- One combinational sub-module, lsu_align: takes funct3, addr[1:0], wdata and the read word. It produces the byte-lane write mask, the shifted store data, the extended load data and the misalign flag.
- The top level holds the FSM, clr_idx counter, array and output registers.

Test Plan:
- Reset, then rst low: busy=1 and req_ready=0 for 64 cycles. Then busy=0, and LW of every word address 0x00..0xFC returns 0x00000000.
- SW 0xDEADBEEF @0x10, then LB @0x10 -> 0xFFFFFFEF; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SW 0x11223344 @0x20, SB 0xAA @0x21, SH 0x5566 @0x22, then LW @0x20 -> 0x5566AA44.
- LH @0x01 and SW @0x06: err pulses 1 cycle after each; LW @0x04 is unchanged. Load funct3=011 -> err=1, rdata_valid=1, rdata=0.
- clr=1 together with req_valid (SW @0x30) in IDLE: store not accepted; busy for 64 cycles. Afterwards, LW @0x30 -> 0.
- rst pulsed at cycle 20 of a clear: sweep restarts and busy lasts a further 64 cycles. A back-to-back SW then LW @0x08 returns the stored value with rdata_valid on the cycle after the LW.
